// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : op encodings, FSM states and helpers for muldiv_iter    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic c_STOP   = 1'b1;
  localparam logic c_NOSTOP = 1'b0;

  // Widest value cond_neg handles; callers cast in and truncate out.
  localparam int MD_MAXW = 128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic [MD_MAXW-1:0] cond_neg(input logic [MD_MAXW-1:0] value,
                                                  input logic flag);
    return flag ? (~value + MD_MAXW'(1)) : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_if : request/result bundle between EX stage and muldiv_iter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             annul_i;
  logic             stallreq_o;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dz_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  stallreq_o, busy_o, ready_o, hi_o, lo_o, dz_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output stallreq_o, busy_o, ready_o, hi_o, lo_o, dz_o
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_iter : iterative MULT/MULTU/DIV/DIVU on a shared datapath     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic clk,
  input  wire logic rst,
  muldiv_if.slave   bus
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_op;
  logic                   r_sa;
  logic                   r_sb;
  logic                   r_dz;
  logic [WIDTH-1:0]       r_a;
  logic [WIDTH-1:0]       r_b;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic [2*WIDTH-1:0]     r_acc;
  logic [CNT_W-1:0]       r_cnt;

  logic                   w_is_div;
  logic                   w_last;
  logic                   w_stall;
  logic                   w_busy;
  logic                   w_ready;
  logic                   w_dz;
  logic [WIDTH-1:0]       w_abs_a;
  logic [WIDTH-1:0]       w_abs_b;
  logic [WIDTH:0]         w_mul_sum;
  logic [2*WIDTH-1:0]     w_mul_nxt;
  logic [WIDTH:0]         w_div_t;
  logic                   w_div_ge;
  logic [WIDTH-1:0]       w_div_r;
  logic [2*WIDTH-1:0]     w_div_nxt;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quo;
  logic [WIDTH-1:0]       w_rem;
  logic [WIDTH-1:0]       w_fix_hi;
  logic [WIDTH-1:0]       w_fix_lo;

  assign w_is_div = r_op[1];
  assign w_last   = (r_cnt == c_LAST);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    if (bus.annul_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start_i) w_state_nxt = ST_PREP;
        ST_PREP: w_state_nxt = ST_RUN;
        ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
        ST_FIX:  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // The IDLE stall term is combinational so the issuing instruction holds in its first EX cycle.
  always_comb begin
    w_stall = c_NOSTOP;
    w_ready = 1'b0;
    w_dz    = 1'b0;
    w_busy  = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: w_stall = (bus.start_i & ~bus.annul_i) ? c_STOP : c_NOSTOP;
      ST_PREP, ST_RUN, ST_FIX: w_stall = c_STOP;
      ST_DONE: begin
        w_ready = 1'b1;
        w_dz    = r_dz;
      end
      default: w_stall = c_NOSTOP;
    endcase
  end

  assign bus.stallreq_o = w_stall;
  assign bus.busy_o     = w_busy;
  assign bus.ready_o    = w_ready;
  assign bus.dz_o       = w_dz;
  assign bus.hi_o       = r_hi;
  assign bus.lo_o       = r_lo;

  // ---------------- datapath ----------------
  assign w_abs_a = WIDTH'(cond_neg(MD_MAXW'(r_a), r_sa));
  assign w_abs_b = WIDTH'(cond_neg(MD_MAXW'(r_b), r_sb));

  // Multiply: accumulator = {partial product, remaining multiplier bits}.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: accumulator = {remainder, dividend bits shifting into quotient}.
  assign w_div_t   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge  = (w_div_t >= {1'b0, r_b});
  assign w_div_r   = w_div_ge ? WIDTH'(w_div_t - {1'b0, r_b}) : w_div_t[WIDTH-1:0];
  assign w_div_nxt = {w_div_r, r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod = (2*WIDTH)'(cond_neg(MD_MAXW'(r_acc), r_sa ^ r_sb));
  assign w_quo  = WIDTH'(cond_neg(MD_MAXW'(r_acc[WIDTH-1:0]), r_sa ^ r_sb));
  assign w_rem  = WIDTH'(cond_neg(MD_MAXW'(r_acc[2*WIDTH-1:WIDTH]), r_sa));

  // A zero divisor leaves |dividend| in the remainder, so hi already equals the sampled opa.
  assign w_fix_hi = w_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = w_is_div ? (r_dz ? '1 : w_quo) : w_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op  <= MD_MULT;
      r_sa  <= 1'b0;
      r_sb  <= 1'b0;
      r_dz  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            r_op <= bus.op_i;
            r_sa <= ~bus.op_i[0] & bus.opa_i[WIDTH-1];
            r_sb <= ~bus.op_i[0] & bus.opb_i[WIDTH-1];
            r_dz <= bus.op_i[1] & (bus.opb_i == '0);
            r_a  <= bus.opa_i;
            r_b  <= bus.opb_i;
          end
        end
        ST_PREP: begin
          r_a   <= w_abs_a;
          r_b   <= w_abs_b;
          r_acc <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
          r_cnt <= '0;
        end
        ST_RUN: begin
          r_acc <= w_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!bus.annul_i) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_iter : directed + random scoreboard bench for muldiv_iter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_iter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t m;
    logic signed [63:0] sa, sbv, p, q, r;
    logic [63:0] up;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    m.dz = 1'b0;
    case (op)
      MD_MULT:  begin p = sa * sbv; m.hi = p[63:32]; m.lo = p[31:0]; end
      MD_MULTU: begin up = {32'h0, a} * {32'h0, b}; m.hi = up[63:32]; m.lo = up[31:0]; end
      default: begin
        if (b == 0) begin
          m.hi = a; m.lo = '1; m.dz = 1'b1;
        end else if (op == MD_DIV) begin
          q = sa / sbv; r = sa % sbv; m.hi = r[31:0]; m.lo = q[31:0];
        end else begin
          m.hi = a % b; m.lo = a / b;
        end
      end
    endcase
    return m;
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives a request at the current negedge (state must be IDLE) and checks its result.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit timing, input bit hold);
    int   n;
    bit   stall_ok;
    exp_t e;
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    sb_q.push_back(model(op, a, b));
    #1 stall_ok = (bus.stallreq_o === 1'b1);
    @(negedge clk);
    if (!hold) bus.start_i = 1'b0;
    bus.opa_i = $urandom;
    bus.opb_i = $urandom;
    bus.op_i  = 2'($urandom_range(0, 3));
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 60) begin
      if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    if (bus.ready_o !== 1'b1 || sb_q.size() == 0) begin
      check({tag, " ready timeout"}, 72'(bus.ready_o), 72'(1));
    end else begin
      e = sb_q.pop_front();
      check({tag, " hi/lo/dz"}, {bus.hi_o, bus.lo_o, 7'b0, bus.dz_o}, {e.hi, e.lo, 7'b0, e.dz});
      if (timing) begin
        check({tag, " latency"}, 72'(n), 72'(W + 2));
        check({tag, " stall window"}, 72'(stall_ok), 72'(1));
        check({tag, " stall in DONE"}, 72'(bus.stallreq_o), 72'(0));
      end
      @(negedge clk);
      check({tag, " pulse end"}, {69'b0, bus.ready_o, bus.dz_o, bus.busy_o}, 72'(0));
      if (hold) bus.start_i = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = MD_MULT;
    bus.opa_i   = '0;
    bus.opb_i   = '0;
    bus.annul_i = 1'b0;
    repeat (2) @(negedge clk);
    check("reset outputs", {bus.hi_o, bus.lo_o, 4'b0, bus.ready_o, bus.dz_o, bus.busy_o, bus.stallreq_o},
          72'(0));
    rst = 1'b0;
    @(negedge clk);

    run_op("MULTU ffff*ffff", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("MULT -3*7", MD_MULT, -32'sd3, 32'd7, 1'b0, 1'b0);
    run_op("MULT min*min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("DIV -7/2", MD_DIV, -32'sd7, 32'd2, 1'b0, 1'b0);
    run_op("DIV min/-1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("DIVU 5/0", MD_DIVU, 32'd5, 32'd0, 1'b1, 1'b0);
    run_op("DIVU 9/3", MD_DIVU, 32'd9, 32'd3, 1'b0, 1'b0);
    run_op("DIVU 7/2", MD_DIVU, 32'd7, 32'd2, 1'b0, 1'b0);

    // Abort at RUN iteration 10; previous result (hi=1, lo=3) must survive.
    bus.start_i = 1'b1; bus.op_i = MD_DIVU; bus.opa_i = 32'd100; bus.opb_i = 32'd7;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul", {bus.hi_o, bus.lo_o, 5'b0, bus.ready_o, bus.dz_o, bus.busy_o},
          {32'h1, 32'h3, 8'h0});
    run_op("start after annul, held", MD_DIV, -32'sd7, 32'd2, 1'b1, 1'b1);

    // Reset mid-operation.
    bus.start_i = 1'b1; bus.op_i = MD_MULT; bus.opa_i = 32'd3; bus.opb_i = 32'd5;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid-op", {bus.hi_o, bus.lo_o, 4'b0, bus.ready_o, bus.dz_o, bus.busy_o, bus.stallreq_o},
          72'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1:       rb = '1;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      run_op("random", 2'($urandom_range(0, 3)), ra, rb, 1'b0, 1'b0);
    end

    check("scoreboard empty", 72'(sb_q.size()), 72'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
